uart_rx_ctrl: RTL and testbench

Receive-side sequencer for the UART datapath. Oversamples the serial line, detects and qualifies the start bit, and drives the 8-bit SIPO shift register's enable at each data-bit midpoint. Checks the stop bit, captures the SIPO's parallel word into a holding register, and presents it to the system through a valid/ready handshake. Sits between the `rx` pin and the host-side receive logic; the SIPO instance sits beside it, fed by `sipo_in`/`shift_en`.

---
 rtl/uart_rx_ctrl.sv | 121 ++++++++++++
 tb/tb_uart_rx_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: synchronizes rx, qualifies the start bit, strobes an external SIPO at
// each data-bit midpoint, checks the stop bit and hands the byte over via valid/ready.
module uart_rx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic       shift_en_o,
  output logic       sipo_in_o,
  input  logic [7:0] sipo_data_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       busy_o,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned Half = CLKS_PER_BIT / 2;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic            rx_meta_q, rx_sync_q;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            shift_en;
  logic            capture;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx_i;
      rx_sync_q   <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_en    = 1'b0;
    capture     = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_sync_q) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == CntW'(Half - 1)) begin
          cnt_d   = '0;
          // A high line at the half-bit point was only a glitch.
          state_d = rx_sync_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == CntW'(CLKS_PER_BIT - 1)) begin
          shift_en = 1'b1;
          cnt_d    = '0;
          idx_d    = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == CntW'(CLKS_PER_BIT - 1)) begin
          cnt_d       = '0;
          state_d     = StIdle;
          capture     = rx_sync_q;
          frame_err_d = ~rx_sync_q;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A capture coinciding with rx_ready consumes the old byte, so it is not an overrun.
  always_comb begin
    rx_data_d  = capture ? sipo_data_i : rx_data_q;
    rx_valid_d = capture | (rx_valid_q & ~rx_ready_i);
    overrun_d  = capture & rx_valid_q & ~rx_ready_i;
  end

  assign shift_en_o  = shift_en;
  assign sipo_in_o   = rx_sync_q;
  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign busy_o      = (state_q != StIdle);
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a behavioural right-shifting SIPO beside the DUT.
module tb_uart_rx_ctrl;

  localparam int unsigned Cpb = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic       shift_en, sipo_in, rx_valid, busy, frame_err, overrun;
  logic [7:0] sipo_data = 8'h00;
  logic [7:0] rx_data;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int se_q[$];
  int fe_q[$];
  int ov_q[$];
  int rv_q[$];
  logic prev_valid = 1'b0;

  uart_rx_ctrl #(.CLKS_PER_BIT(Cpb)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .rx_i       (rx),
    .shift_en_o (shift_en),
    .sipo_in_o  (sipo_in),
    .sipo_data_i(sipo_data),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .rx_ready_i (rx_ready),
    .busy_o     (busy),
    .frame_err_o(frame_err),
    .overrun_o  (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (shift_en) sipo_data <= {sipo_in, sipo_data[7:1]};
  end

  always @(negedge clk) begin
    if (shift_en) se_q.push_back(cyc);
    if (frame_err) fe_q.push_back(cyc);
    if (overrun) ov_q.push_back(cyc);
    if (rx_valid && !prev_valid) rv_q.push_back(cyc);
    prev_valid <= rx_valid;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) tick();
    @(negedge clk);
  endtask

  task automatic clear_logs();
    se_q.delete();
    fe_q.delete();
    ov_q.delete();
    rv_q.delete();
  endtask

  // Starts on the next edge; t0 is the first cycle the synchronized line reads low.
  task automatic send_frame(input logic [7:0] d, input logic stop, output int t0);
    tick();
    rx = 1'b0;
    t0 = cyc + 2;
    repeat (Cpb) tick();
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (Cpb) tick();
    end
    rx = stop;
    repeat (Cpb) tick();
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    n_cmp++; if (shift_en !== 1'b0) begin n_err++; $display("FAIL reset_shift_en: got %b want 0", shift_en); end
    n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    n_cmp++; if (sipo_in !== 1'b1) begin n_err++; $display("FAIL reset_sipo_in: got %b want 1", sipo_in); end
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_basic();
    int t0;
    clear_logs();
    rx_ready = 1'b0;
    send_frame(8'hA5, 1'b1, t0);
    wait_to(t0 + 160);
    n_cmp++; if (se_q.size() != 8) begin n_err++; $display("FAIL basic_shift_count: got %0d want 8", se_q.size()); end
    for (int k = 0; k < 8 && k < se_q.size(); k++) begin
      n_cmp++;
      if (se_q[k] != t0 + 24 + 16 * k) begin
        n_err++; $display("FAIL basic_shift_time[%0d]: got %0d want %0d", k, se_q[k], t0 + 24 + 16 * k);
      end
    end
    n_cmp++; if (rv_q.size() != 1 || rv_q[0] != t0 + 153) begin n_err++; $display("FAIL basic_valid_time: got %p want %0d", rv_q, t0 + 153); end
    n_cmp++; if (rx_data !== 8'hA5) begin n_err++; $display("FAIL basic_rx_data: got %h want a5", rx_data); end
    n_cmp++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL basic_rx_valid: got %b want 1", rx_valid); end
    n_cmp++; if (fe_q.size() != 0) begin n_err++; $display("FAIL basic_frame_err: got %0d pulses want 0", fe_q.size()); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_after: got %b want 0", busy); end
  endtask

  task automatic consume();
    tick();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL consume_rx_valid: got %b want 0", rx_valid); end
  endtask

  task automatic test_glitch();
    int t0;
    clear_logs();
    tick();
    rx = 1'b0;
    t0 = cyc + 2;
    repeat (4) tick();
    rx = 1'b1;
    wait_to(t0 + 8);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL glitch_busy_in_start: got %b want 1", busy); end
    wait_to(t0 + 9);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy_idle: got %b want 0", busy); end
    wait_to(t0 + 60);
    n_cmp++; if (se_q.size() != 0 || fe_q.size() != 0 || rv_q.size() != 0) begin
      n_err++; $display("FAIL glitch_no_events: got shifts=%0d ferr=%0d valid=%0d want 0/0/0",
                        se_q.size(), fe_q.size(), rv_q.size());
    end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_frame_err();
    int t0;
    clear_logs();
    send_frame(8'h3C, 1'b0, t0);
    wait_to(t0 + 190);
    n_cmp++; if (fe_q.size() != 1 || fe_q[0] != t0 + 153) begin n_err++; $display("FAIL ferr_pulse: got %p want one at %0d", fe_q, t0 + 153); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL ferr_rx_valid: got %b want 0", rx_valid); end
    n_cmp++; if (rx_data !== 8'hA5) begin n_err++; $display("FAIL ferr_rx_data: got %h want a5", rx_data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ferr_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int t0a, t0b, t0c;
    clear_logs();
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, t0a);
    send_frame(8'h22, 1'b1, t0b);
    wait_to(t0b + 160);
    n_cmp++; if (ov_q.size() != 1 || ov_q[0] != t0b + 153) begin n_err++; $display("FAIL b2b_overrun: got %p want one at %0d", ov_q, t0b + 153); end
    n_cmp++; if (rx_data !== 8'h22) begin n_err++; $display("FAIL b2b_rx_data: got %h want 22", rx_data); end
    n_cmp++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL b2b_rx_valid: got %b want 1", rx_valid); end
    clear_logs();
    fork
      send_frame(8'h33, 1'b1, t0c);
      begin
        int t0;
        tick();
        t0 = cyc + 2;
        while (cyc < t0 + 152) tick();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
      end
    join
    wait_to(t0c + 165);
    n_cmp++; if (ov_q.size() != 0) begin n_err++; $display("FAIL b2b_ready_overrun: got %0d pulses want 0", ov_q.size()); end
    n_cmp++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL b2b_ready_rx_valid: got %b want 1", rx_valid); end
    n_cmp++; if (rx_data !== 8'h33) begin n_err++; $display("FAIL b2b_ready_rx_data: got %h want 33", rx_data); end
  endtask

  task automatic test_handshake();
    int t0;
    consume();
    send_frame(8'h5A, 1'b1, t0);
    for (int i = 0; i < 10; i++) begin
      wait_to(t0 + 153 + i);
      n_cmp++; if (rx_data !== 8'h5A || rx_valid !== 1'b1) begin
        n_err++; $display("FAIL hs_hold[%0d]: got data=%h valid=%b want 5a/1", i, rx_data, rx_valid);
      end
    end
    tick();
    rx_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL hs_valid_during_ready: got %b want 1", rx_valid); end
    tick();
    rx_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL hs_valid_fall: got %b want 0", rx_valid); end
    n_cmp++; if (rx_data !== 8'h5A) begin n_err++; $display("FAIL hs_data_after: got %h want 5a", rx_data); end
  endtask

  task automatic test_reset_mid_frame();
    int t0f, t0g;
    fork
      send_frame(8'hFF, 1'b1, t0f);
      begin
        int t0;
        tick();
        t0 = cyc + 2;
        while (cyc < t0 + 80) tick();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || shift_en !== 1'b0) begin
          n_err++; $display("FAIL rstmid_state: got busy=%b shift_en=%b want 0/0", busy, shift_en);
        end
        n_cmp++; if (rx_data !== 8'h00 || rx_valid !== 1'b0) begin
          n_err++; $display("FAIL rstmid_outputs: got data=%h valid=%b want 00/0", rx_data, rx_valid);
        end
        n_cmp++; if (sipo_in !== 1'b1 || frame_err !== 1'b0 || overrun !== 1'b0) begin
          n_err++; $display("FAIL rstmid_misc: got sipo_in=%b ferr=%b ovr=%b want 1/0/0", sipo_in, frame_err, overrun);
        end
        repeat (2) tick();
        rst_n = 1'b1;
      end
    join
    repeat (4) tick();
    clear_logs();
    send_frame(8'h81, 1'b1, t0g);
    wait_to(t0g + 160);
    n_cmp++; if (rx_data !== 8'h81 || rx_valid !== 1'b1) begin
      n_err++; $display("FAIL rstmid_next_frame: got data=%h valid=%b want 81/1", rx_data, rx_valid);
    end
    n_cmp++; if (se_q.size() != 8) begin n_err++; $display("FAIL rstmid_shift_count: got %0d want 8", se_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    consume();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_handshake();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
